// File: rtl/pll_reset_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// The state type and the retry-counter width are visible to any PLL-domain logic that imports this package.
package pll_reset_seq_pkg;

  localparam int RETRIES_W = 4;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One spare bit keeps the terminal count comfortably representable.
  function automatic int cnt_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Both flops clear to 0 on reset, so a clear or reset reads as "not asserted".
module sync_2ff
  import pll_reset_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments are what make this a two-stage shift; blocking would collapse it to one flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Holds the ECP5 PLL in reset, waits for a stable lock, then releases the downstream system reset.
// Lock loss re-sequences, lock timeouts retry, and too many failed attempts latch FAULT until rst.
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int RST_CYCLES         = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                 clk25,
  input  logic                 rst,
  input  logic                 pll_lock,
  output logic                 pll_rst,
  output logic                 sys_rst,
  output logic                 ready,
  output logic                 fault,
  output logic                 lock_lost,
  output logic [RETRIES_W-1:0] retries
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT);

  localparam logic [CNT_W-1:0]     RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]     STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRIES_W-1:0] RETRY_LIMIT  = RETRIES_W'(MAX_RETRIES);

  logic lock_s;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRIES_W-1:0] retries_q, retries_d, retries_inc;
  logic                 pll_rst_q, sys_rst_q, ready_q, fault_q, lock_lost_q;
  logic                 pll_rst_d, sys_rst_d, ready_d, fault_d, lock_lost_d;

  sync_2ff u_lock_sync (
    .clk_i (clk25),
    .rst_i (rst),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  assign retries_inc = (retries_q == RETRY_LIMIT) ? retries_q : retries_q + 1'b1;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    retries_d   = retries_q;
    lock_lost_d = 1'b0;

    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle takes priority over the retry.
        if (lock_s) begin
          state_d = SETTLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == RETRY_LIMIT) ? FAULT : RESET_PLL;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = RUN;
          retries_d = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d     = RESET_PLL;
          lock_lost_d = 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // Outputs decode the next state so they change on the same edge as the state itself.
  always_comb begin
    pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retries_q   <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign lock_lost = lock_lost_q;
  assign retries   = retries_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: a timeline reference model predicts every output cycle,
// a monitor compares on the falling edge, and directed scenarios pin the documented latencies.
module tb_pll_reset_seq;

  localparam int RST_C     = 4;
  localparam int STABLE_C  = 8;
  localparam int TIMEOUT_C = 32;
  localparam int MAXR_C    = 2;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [3:0] retries;
  } out_t;

  localparam out_t RST_OUT = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0,
                               lock_lost: 1'b0, retries: 4'd0};

  typedef enum int {M_HOLD, M_WAIT, M_STAB, M_UP, M_DEAD} phase_e;

  logic       clk25 = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       pll_rst, sys_rst, ready, fault, lock_lost;
  logic [3:0] retries;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  out_t exp_q[$];

  pll_reset_seq #(
    .RST_CYCLES        (RST_C),
    .LOCK_STABLE_CYCLES(STABLE_C),
    .LOCK_TIMEOUT      (TIMEOUT_C),
    .MAX_RETRIES       (MAXR_C)
  ) dut (
    .clk25    (clk25),
    .rst      (rst),
    .pll_lock (pll_lock),
    .pll_rst  (pll_rst),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .fault    (fault),
    .lock_lost(lock_lost),
    .retries  (retries)
  );

  always #5 clk25 = ~clk25;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Edge counter since the last reset release; edge k is the k-th clk25 rise after rst falls.
  initial forever begin
    @(posedge clk25 or posedge rst);
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
  end

  // Reference model: tracks which phase the sequencer is in and how long it has dwelt there.
  phase_e m_ph    = M_HOLD;
  int     m_entry = 0;
  int     m_cyc   = 0;
  int     m_fails = 0;
  bit     m_hist[$];

  function automatic void m_enter(input phase_e p);
    m_ph    = p;
    m_entry = m_cyc;
  endfunction

  initial forever begin
    @(posedge clk25 or posedge rst);
    if (rst) begin
      m_ph = M_HOLD; m_entry = 0; m_cyc = 0; m_fails = 0;
      m_hist.delete();
      exp_q.delete();
    end else begin
      bit   ls;
      bit   lost;
      int   dwell;
      out_t e;
      m_cyc++;
      ls = (m_hist.size() >= 2) ? m_hist[1] : 1'b0;
      m_hist.push_front(pll_lock);
      if (m_hist.size() > 2) void'(m_hist.pop_back());
      dwell = m_cyc - m_entry;
      lost  = 1'b0;
      case (m_ph)
        M_HOLD: if (dwell == RST_C) m_enter(M_WAIT);
        M_WAIT: begin
          if (ls) m_enter(M_STAB);
          else if (dwell == TIMEOUT_C) begin
            if (m_fails < MAXR_C) m_fails++;
            m_enter((m_fails == MAXR_C) ? M_DEAD : M_HOLD);
          end
        end
        M_STAB: begin
          if (!ls) m_enter(M_WAIT);
          else if (dwell == STABLE_C) begin
            m_fails = 0;
            m_enter(M_UP);
          end
        end
        M_UP: if (!ls) begin
          lost = 1'b1;
          m_enter(M_HOLD);
        end
        default: ;
      endcase
      e.pll_rst   = (m_ph == M_HOLD) || (m_ph == M_DEAD);
      e.sys_rst   = (m_ph != M_UP);
      e.ready     = (m_ph == M_UP);
      e.fault     = (m_ph == M_DEAD);
      e.lock_lost = lost;
      e.retries   = 4'(m_fails);
      exp_q.push_back(e);
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  initial forever begin
    out_t act, e;
    @(negedge clk25);
    act = '{pll_rst: pll_rst, sys_rst: sys_rst, ready: ready, fault: fault,
            lock_lost: lock_lost, retries: retries};
    if (rst) begin
      check("reset_outputs", 32'(act), 32'(RST_OUT));
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("outputs@%0d", cyc), 32'(act), 32'(e));
    end
  end

  // Drives pll_lock for the next n sampling edges; returns 2 ns after the last one.
  task automatic hold(input logic v, input int n);
    pll_lock = v;
    repeat (n) @(posedge clk25);
    #2;
  endtask

  task automatic reset_dut(input logic lock_v);
    @(posedge clk25);
    #3;
    rst      = 1'b1;
    pll_lock = lock_v;
    #1;
    check("async_rst_sys_rst", sys_rst, 1);
    check("async_rst_pll_rst", pll_rst, 1);
    check("async_rst_ready", ready, 0);
    check("async_rst_fault", fault, 0);
    repeat (2) @(posedge clk25);
    #2;
    rst = 1'b0;
  endtask

  task automatic run_until_ready(input logic v, input int budget, output int edge_k);
    edge_k = -1;
    for (int i = 0; i < budget; i++) begin
      hold(v, 1);
      if (ready) begin
        edge_k = cyc;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_a, t_b, t_c, a;
    rst      = 1'b0;
    pll_lock = 1'b1;
    #1 rst   = 1'b1;
    repeat (3) @(posedge clk25);
    #2 rst = 1'b0;

    // Clean bring-up with lock tied high.
    t_a = -1;
    t_b = -1;
    for (int i = 0; i < 40 && t_b < 0; i++) begin
      hold(1'b1, 1);
      if (!pll_rst && t_a < 0) t_a = cyc;
      if (ready) t_b = cyc;
    end
    check("bringup_pll_rst_fall", t_a, RST_C);
    check("bringup_release_cycle", t_b, RST_C + 1 + STABLE_C);
    check("bringup_sys_rst", sys_rst, 0);
    check("bringup_retries", retries, 0);

    // Lock loss while running.
    hold(1'b1, 5);
    a = cyc + 1;
    hold(1'b0, 2);
    check("loss_ready_held", ready, 1);
    check("loss_no_early_pulse", lock_lost, 0);
    hold(1'b0, 1);
    check("loss_pulse", lock_lost, 1);
    check("loss_sys_rst", sys_rst, 1);
    check("loss_ready_drop", ready, 0);
    hold(1'b1, 1);
    check("loss_pulse_width", lock_lost, 0);
    check("loss_pll_rst", pll_rst, 1);
    run_until_ready(1'b1, 60, t_b);
    check("reseq_release_cycle", t_b, a + 2 + RST_C + 1 + STABLE_C);
    check("reseq_retries", retries, 0);

    // Asynchronous reset while in RUN.
    check("run_before_rst", ready, 1);
    reset_dut(1'b0);

    // Lock never arrives: two timeouts lead to FAULT.
    t_a = -1;
    t_b = -1;
    t_c = -1;
    for (int i = 0; i < 120 && t_c < 0; i++) begin
      hold(1'b0, 1);
      if (retries == 4'd1 && t_a < 0) t_a = cyc;
      if (t_a >= 0 && t_b < 0 && !pll_rst) t_b = cyc;
      if (fault) t_c = cyc;
    end
    check("timeout_first_retry", t_a, RST_C + TIMEOUT_C);
    check("timeout_second_pulse_end", t_b, 2 * RST_C + TIMEOUT_C);
    check("timeout_fault_cycle", t_c, 2 * (RST_C + TIMEOUT_C));
    check("fault_retries", retries, MAXR_C);
    check("fault_pll_rst", pll_rst, 1);
    check("fault_sys_rst", sys_rst, 1);
    hold(1'b1, 20);
    check("fault_sticky", fault, 1);
    check("fault_no_ready", ready, 0);
    check("fault_sticky_retries", retries, MAXR_C);
    reset_dut(1'b0);

    // lock_s rises exactly on the last WAIT_LOCK cycle.
    hold(1'b0, RST_C + TIMEOUT_C - 3);
    hold(1'b1, 3);
    check("simul_retries", retries, 0);
    check("simul_pll_rst", pll_rst, 0);
    check("simul_fault", fault, 0);
    run_until_ready(1'b1, 40, t_b);
    check("simul_release_cycle", t_b, RST_C + TIMEOUT_C + STABLE_C);
    reset_dut(1'b0);

    // One-cycle lock glitch during SETTLE.
    hold(1'b0, 9);
    hold(1'b1, 5);
    hold(1'b0, 1);
    check("glitch_sys_rst", sys_rst, 1);
    run_until_ready(1'b1, 60, t_b);
    check("glitch_release_cycle", t_b, 18 + STABLE_C);

    // Randomized lock activity with occasional resets.
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset_dut(1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) != 0) begin
        hold(1'b1, $urandom_range(1, 30));
      end else begin
        hold(1'b0, $urandom_range(1, 40));
      end
    end
    hold(1'b1, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
